// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: access-size encodings,
// fault codes, FSM state type and request-classification helpers.
package lsu_pkg;

  // funct3 access encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Fault codes reported on the response channel
  localparam logic [1:0] LSU_OK       = 2'b00;
  localparam logic [1:0] LSU_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_ILLEGAL  = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_RESP     = 3'd4
  } lsu_state_e;

  // Unsigned variants exist only for loads; everything else is illegal.
  function automatic logic lsu_illegal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
         (!store && ((f3 == LSU_BU) || (f3 == LSU_HU)));
    return !ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (f3[1:0] == 2'b01 && off[0]) mis = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the sequencer: extracts and extends load data from
// a memory word, and merges partial store data into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then sign- or zero-extend by access type
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LSU_B:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data_o = {24'h000000, byte_sel};
      LSU_H:   load_data_o = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Overlay the store bytes onto the word read back from memory
  always_comb begin
    store_word_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        store_word_o = rdata_i;
        store_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      2'b01: begin
        store_word_o = rdata_i;
        if (off_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else          store_word_o[15:0]  = wdata_i[15:0];
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer. Accepts one request at a time, checks
// alignment and encoding, performs word reads (with read-modify-write for
// sub-word stores) and returns the result or a fault to writeback.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_en_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_wdata_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_we_o,
  output logic [1:0]  rsp_fault_o
);

  // Counter value at which the last permitted wait cycle expires
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  lsu_state_e state_q, state_d;

  // Request capture
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic        req_ready_q, req_ready_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic        rsp_we_q, rsp_we_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_align u_align (
    .rdata_i      (mem_rdata_i),
    .wdata_i      (wdata_q),
    .off_i        (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // State, capture and output registers; reset aborts any access at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_we_q    <= 1'b0;
      rsp_fault_q <= LSU_OK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_we_q    <= rsp_we_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so strobes
  // come straight out of flops
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_we_d    = rsp_we_q;
    rsp_fault_d = rsp_fault_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d      = req_addr_i;
          funct3_d    = req_funct3_i;
          store_d     = req_store_i;
          wdata_d     = req_wdata_i;
          rd_d        = req_rd_i;
          rsp_data_d  = '0;
          rsp_we_d    = 1'b0;
          rsp_fault_d = LSU_OK;
          if (lsu_illegal(req_store_i, req_funct3_i)) begin
            rsp_fault_d = LSU_ILLEGAL;
            state_d     = S_RESP;
          end else if (lsu_misaligned(req_funct3_i, req_addr_i[1:0])) begin
            rsp_fault_d = LSU_MISALIGN;
            state_d     = S_RESP;
          end else if (req_store_i && req_funct3_i == LSU_W) begin
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (store_q) begin
            wdata_d = store_word;
            state_d = S_WR_ISSUE;
          end else begin
            rsp_data_d = load_data;
            rsp_we_d   = 1'b1;
            state_d    = S_RESP;
          end
        end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          rsp_fault_d = LSU_TIMEOUT;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_ISSUE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_data_d  = '0;
          rsp_we_d    = 1'b0;
          rsp_fault_d = LSU_OK;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    mem_rd_en_d = (state_d == S_RD_ISSUE);
    mem_wr_en_d = (state_d == S_WR_ISSUE);
    mem_addr_d  = '0;
    if (state_d == S_RD_ISSUE || state_d == S_RD_WAIT || state_d == S_WR_ISSUE) begin
      mem_addr_d = {addr_d[31:2], 2'b00};
    end
    mem_wdata_d = (state_d == S_WR_ISSUE) ? wdata_d : '0;
    rsp_valid_d = (state_d == S_RESP);
    rsp_rd_d    = (state_d == S_RESP) ? rd_d : '0;
  end

  assign req_ready_o = req_ready_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_fault_o = rsp_fault_q;

endmodule
